// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link blocks: FSM encoding and the counter-width helper.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  // Counters need at least one bit even when they only ever hold zero.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Frame position counter: bit within slot and slot within frame.
// restart means "the current bit is position 0", so the counters land on the position after it.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          advance,
  input  logic                          restart,
  output logic [cnt_width(WIDTH)-1:0]    bit_cnt,
  output logic [cnt_width(CHANNELS)-1:0] slot_cnt,
  output logic                          at_first,
  output logic                          at_last
);

  localparam int BIT_W  = cnt_width(WIDTH);
  localparam int SLOT_W = cnt_width(CHANNELS);
  localparam logic ONE_BIT_FRAME = ((CHANNELS * WIDTH) == 1);

  logic [BIT_W-1:0]  base_bit;
  logic [BIT_W-1:0]  next_bit;
  logic [SLOT_W-1:0] base_slot;
  logic [SLOT_W-1:0] next_slot;
  logic              base_last;

  assign at_first = (bit_cnt == BIT_W'(0)) && (slot_cnt == SLOT_W'(0));
  assign at_last  = (bit_cnt == BIT_W'(WIDTH - 1)) && (slot_cnt == SLOT_W'(CHANNELS - 1));

  // Next position: optionally rebase to position 0, then step once.
  always_comb begin
    base_bit  = bit_cnt;
    base_slot = slot_cnt;
    base_last = at_last;
    if (restart) begin
      base_bit  = BIT_W'(0);
      base_slot = SLOT_W'(0);
      base_last = ONE_BIT_FRAME;
    end else begin
      base_last = at_last;
    end

    next_bit  = bit_cnt;
    next_slot = slot_cnt;
    if (restart || advance) begin
      if (base_last) begin
        next_bit  = BIT_W'(0);
        next_slot = SLOT_W'(0);
      end else if (base_bit == BIT_W'(WIDTH - 1)) begin
        next_bit  = BIT_W'(0);
        next_slot = base_slot + SLOT_W'(1);
      end else begin
        next_bit  = base_bit + BIT_W'(1);
        next_slot = base_slot;
      end
    end else begin
      next_bit  = bit_cnt;
      next_slot = slot_cnt;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt  <= BIT_W'(0);
      slot_cnt <= SLOT_W'(0);
    end else begin
      bit_cnt  <= next_bit;
      slot_cnt <= next_slot;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Receive side of the serial TDM link: hunts for frame sync, deserialises each frame
// into CHANNELS words of WIDTH bits and presents them together with a one-cycle strobe.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         bit_valid,
  input  logic                         data_in,
  input  logic                         frame_sync,
  input  logic                         sync_err_clr,
  output logic [CHANNELS*WIDTH-1:0]    ch_out,
  output logic                         frame_valid,
  output logic                         locked,
  output logic                         sync_err
);

  localparam int FRAME_BITS = CHANNELS * WIDTH;
  localparam int BIT_W      = cnt_width(WIDTH);
  localparam int SLOT_W     = cnt_width(CHANNELS);
  localparam logic ONE_BIT_FRAME = (FRAME_BITS == 1);

  state_t                state;
  logic [FRAME_BITS-1:0] shadow;
  logic [FRAME_BITS-1:0] next_shadow;
  logic [BIT_W-1:0]      bit_cnt;
  logic [SLOT_W-1:0]     slot_cnt;
  logic                  at_first;
  logic                  at_last;
  logic                  take;
  logic                  resync;
  logic                  err;
  logic                  complete;
  logic [SLOT_W-1:0]     cur_slot;
  int                    slot_base;

  // Slot words fill MSB first, so each new bit enters at the LSB end.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word, input logic d);
    logic [WIDTH:0] t;
    t = {word, d};
    return t[WIDTH-1:0];
  endfunction

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH)
  ) u_slot_counter (
    .clock    (clock),
    .reset    (reset),
    .advance  (take && !resync),
    .restart  (resync),
    .bit_cnt  (bit_cnt),
    .slot_cnt (slot_cnt),
    .at_first (at_first),
    .at_last  (at_last)
  );

  // Decode what the current bit does to framing, and build the updated shadow frame.
  always_comb begin
    take   = 1'b0;
    resync = 1'b0;
    err    = 1'b0;
    if (bit_valid) begin
      if (state == RECV) begin
        take   = 1'b1;
        resync = frame_sync && !at_first;
        err    = frame_sync && !at_first;
      end else begin
        take   = frame_sync;
        resync = frame_sync;
        err    = 1'b0;
      end
    end else begin
      take   = 1'b0;
      resync = 1'b0;
      err    = 1'b0;
    end

    cur_slot  = resync ? SLOT_W'(0) : slot_cnt;
    slot_base = int'(cur_slot) * WIDTH;
    complete  = take && (resync ? ONE_BIT_FRAME : at_last);

    next_shadow = shadow;
    if (take) begin
      next_shadow[slot_base +: WIDTH] = shift_in(shadow[slot_base +: WIDTH], data_in);
    end else begin
      next_shadow = shadow;
    end
  end

  // Framing FSM, output frame register and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      locked      <= 1'b0;
      shadow      <= {FRAME_BITS{1'b0}};
      ch_out      <= {FRAME_BITS{1'b0}};
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      shadow      <= next_shadow;
      frame_valid <= complete;
      if (complete) begin
        ch_out <= next_shadow;
      end
      case (state)
        HUNT: begin
          if (take) begin
            state  <= RECV;
            locked <= 1'b1;
          end
        end
        RECV: begin
          state  <= RECV;
          locked <= 1'b1;
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
      // A new error outranks a clear arriving in the same cycle.
      if (err) begin
        sync_err <= 1'b1;
      end else if (sync_err_clr) begin
        sync_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux at CHANNELS=4, WIDTH=4: table of whole frames plus
// hand-written sequences for resync, error clear, async reset and pre-sync bits.
module tb_tdm_demux;

  logic        clock = 1'b0;
  logic        reset;
  logic        bit_valid;
  logic        data_in;
  logic        frame_sync;
  logic        sync_err_clr;
  logic [15:0] ch_out;
  logic        frame_valid;
  logic        locked;
  logic        sync_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic first_locked;

  typedef struct {
    logic [15:0] frame;
    int          gap;
    logic        sync;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [4];

  tdm_demux #(.CHANNELS(4), .WIDTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .bit_valid    (bit_valid),
    .data_in      (data_in),
    .frame_sync   (frame_sync),
    .sync_err_clr (sync_err_clr),
    .ch_out       (ch_out),
    .frame_valid  (frame_valid),
    .locked       (locked),
    .sync_err     (sync_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v, input logic d, input logic s, input logic c);
    @(negedge clock);
    bit_valid    = v;
    data_in      = d;
    frame_sync   = s;
    sync_err_clr = c;
    @(posedge clock);
    #1;
  endtask

  // Sends 16 bits MSB first; counts frame_valid pulses seen during the frame.
  task automatic send_frame(input logic [15:0] f, input int gap, input logic sync,
                            output int pulses, output logic fv_last, output int pulse_cyc);
    pulses    = 0;
    fv_last   = 1'b0;
    pulse_cyc = -1;
    for (int i = 15; i >= 0; i--) begin
      send_bit(1'b1, f[i], sync && (i == 15), 1'b0);
      if (i == 15) first_locked = locked;
      if (frame_valid) begin
        pulses++;
        pulse_cyc = cyc;
      end
      fv_last = frame_valid;
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          send_bit(1'b0, 1'b0, 1'b0, 1'b0);
          if (frame_valid) pulses++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    bit_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int   pulses;
    int   pc0;
    int   pc1;
    logic fvl;
    logic [15:0] partial;

    vecs[0] = '{frame: 16'hA5C3, gap: 0, sync: 1'b1, exp: 16'h3C5A};
    vecs[1] = '{frame: 16'h0F0F, gap: 0, sync: 1'b1, exp: 16'hF0F0};
    vecs[2] = '{frame: 16'hA5C3, gap: 1, sync: 1'b1, exp: 16'h3C5A};
    vecs[3] = '{frame: 16'hC0DE, gap: 2, sync: 1'b0, exp: 16'hED0C};

    reset = 1'b1; bit_valid = 1'b0; data_in = 1'b0; frame_sync = 1'b0; sync_err_clr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_ch_out", ch_out, 16'h0000);
    check("reset_frame_valid", frame_valid, 1'b0);
    check("reset_locked", locked, 1'b0);
    check("reset_sync_err", sync_err, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < 4; k++) begin
      send_frame(vecs[k].frame, vecs[k].gap, vecs[k].sync, pulses, fvl, pc0);
      check($sformatf("vec%0d_locked_first_bit", k), first_locked, 1'b1);
      check($sformatf("vec%0d_ch_out", k), ch_out, vecs[k].exp);
      check($sformatf("vec%0d_pulses", k), pulses, 1);
      check($sformatf("vec%0d_fv_on_last", k), fvl, 1'b1);
      check($sformatf("vec%0d_sync_err", k), sync_err, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d_fv_one_cycle", k), frame_valid, 1'b0);
      check($sformatf("vec%0d_ch_out_hold", k), ch_out, vecs[k].exp);
    end

    // Back-to-back frames, sync only on the first.
    send_frame(16'h0F0F, 0, 1'b1, pulses, fvl, pc0);
    check("b2b_first_ch_out", ch_out, 16'hF0F0);
    send_frame(16'hF0F0, 0, 1'b0, pulses, fvl, pc1);
    check("b2b_second_ch_out", ch_out, 16'h0F0F);
    check("b2b_second_pulses", pulses, 1);
    check("b2b_pulse_spacing", pc1 - pc0, 16);

    // Mid-frame resync after 7 bits.
    partial = 16'hBEEF;
    for (int i = 15; i >= 9; i--) send_bit(1'b1, partial[i], i == 15, 1'b0);
    check("resync_no_err_before", sync_err, 1'b0);
    send_frame(16'h1234, 0, 1'b1, pulses, fvl, pc0);
    check("resync_sync_err", sync_err, 1'b1);
    check("resync_ch_out", ch_out, 16'h4321);
    check("resync_pulses", pulses, 1);
    send_bit(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_sync_err", sync_err, 1'b0);

    // Error set and clear in the same cycle: set wins.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, i == 0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1, 1'b1);
    check("set_wins_over_clr", sync_err, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_after_set_wins", sync_err, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset after 9 bits of a frame.
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b1, i == 0, 1'b0);
    check("pre_reset_sync_err", sync_err, 1'b1);
    @(negedge clock);
    bit_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("async_reset_ch_out", ch_out, 16'h0000);
    check("async_reset_locked", locked, 1'b0);
    check("async_reset_sync_err", sync_err, 1'b0);
    check("async_reset_frame_valid", frame_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    send_frame(16'h8001, 0, 1'b1, pulses, fvl, pc0);
    check("post_reset_ch_out", ch_out, 16'h1008);
    check("post_reset_pulses", pulses, 1);

    // Valid bits before any sync are ignored.
    do_reset();
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    check("presync_locked", locked, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1, 1'b0);
    check("sync_without_valid_ignored", locked, 1'b0);
    send_frame(16'hFFFF, 0, 1'b1, pulses, fvl, pc0);
    check("presync_ch_out", ch_out, 16'hFFFF);
    check("presync_pulses", pulses, 1);
    check("presync_sync_err", sync_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
